// File: rtl/df_unit_pkg.sv
// Shared constants and types for the df_unit data-fetch sequencer.
package df_unit_pkg;

    localparam int DF_WORD_W = 16;
    localparam int DF_ADDR_W = 8;
    localparam int DF_STAGES = 2;

    // 1.0 in the signed Q.12 operand format
    localparam logic [15:0] DF_ONE = 16'h1000;

    typedef enum logic [1:0] {
        DF_IDLE,
        DF_FETCH,
        DF_DRAIN,
        DF_DONE
    } df_state_e;

    // Per-slot tag travelling alongside a RAM read (or the bias slot)
    typedef struct packed {
        logic vld;
        logic last;
        logic bsel;
    } df_tag_t;

endpackage

// File: rtl/df_unit_pipe.sv
// df_pipe: 2-stage valid/last/data pipeline between the RAM read and the df_rdy strobe.
module df_pipe
    import df_unit_pkg::*;
#(
    parameter int WORD_WIDTH = DF_WORD_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  df_tag_t               tag,
    input  logic [WORD_WIDTH-1:0] w_rdata,
    input  logic [WORD_WIDTH-1:0] i_rdata,
    input  logic [WORD_WIDTH-1:0] bias,
    output logic                  pending,
    output logic                  df_rdy,
    output logic                  df_last,
    output logic [WORD_WIDTH-1:0] data_w,
    output logic [WORD_WIDTH-1:0] data_i
);

    logic [DF_STAGES:1] vld_pipe;
    logic               last_q;
    logic               bsel_q;
    logic               last_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            last_q   <= 1'b0;
            bsel_q   <= 1'b0;
            last_out <= 1'b0;
            data_w   <= '0;
            data_i   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[DF_STAGES-1:1], tag.vld};
            last_q   <= tag.vld & tag.last;
            bsel_q   <= tag.vld & tag.bsel;
            last_out <= vld_pipe[1] & last_q;
            // Operands hold their value between strobes
            if (vld_pipe[1]) begin
                data_w <= bsel_q ? bias : w_rdata;
                data_i <= bsel_q ? WORD_WIDTH'(DF_ONE) : i_rdata;
            end
        end
    end

    assign df_rdy  = vld_pipe[DF_STAGES];
    assign df_last = last_out;
    assign pending = tag.vld | vld_pipe[1];

endmodule

// File: rtl/df_unit.sv
// df_unit: fetches LEN weight/input pairs from two synchronous RAMs and streams them out.
// Optional DF_BIAS_EN appends one (bias, 1.0) pair to every run.
module df_unit
    import df_unit_pkg::*;
#(
    parameter int WORD_WIDTH = DF_WORD_W,
    parameter int ADDR_WIDTH = DF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] len,
    input  logic [ADDR_WIDTH-1:0] w_base,
    input  logic [ADDR_WIDTH-1:0] i_base,
`ifdef DF_BIAS_EN
    input  logic [WORD_WIDTH-1:0] bias,
`endif
    output logic                  w_rd,
    output logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [WORD_WIDTH-1:0] w_rdata,
    output logic                  i_rd,
    output logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [WORD_WIDTH-1:0] i_rdata,
    output logic                  df_rdy,
    output logic [WORD_WIDTH-1:0] data_w,
    output logic [WORD_WIDTH-1:0] data_i,
    output logic                  df_last,
    output logic                  busy,
    output logic                  done
);

    df_state_e             state;
    logic [ADDR_WIDTH-1:0] k;
    logic [ADDR_WIDTH-1:0] len_q;
    logic                  slot_last;
    logic                  bias_slot;
    logic                  pending;
    logic [WORD_WIDTH-1:0] bias_word;
    df_tag_t               tag;

`ifdef DF_BIAS_EN
    logic [WORD_WIDTH-1:0] bias_q;
    assign bias_word = bias_q;
`else
    assign bias_word = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DF_IDLE;
            k         <= '0;
            len_q     <= '0;
            w_rd      <= 1'b0;
            i_rd      <= 1'b0;
            w_addr    <= '0;
            i_addr    <= '0;
            slot_last <= 1'b0;
            bias_slot <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef DF_BIAS_EN
            bias_q    <= '0;
`endif
        end else begin
            done      <= 1'b0;
            bias_slot <= 1'b0;
            case (state)
                DF_IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        k      <= '0;
                        busy   <= 1'b1;
                        w_addr <= w_base;
                        i_addr <= i_base;
`ifdef DF_BIAS_EN
                        bias_q <= bias;
`endif
                        if (len != '0) begin
                            state <= DF_FETCH;
                            w_rd  <= 1'b1;
                            i_rd  <= 1'b1;
`ifdef DF_BIAS_EN
                            slot_last <= 1'b0;
`else
                            slot_last <= (len == ADDR_WIDTH'(1));
`endif
                        end else begin
`ifdef DF_BIAS_EN
                            // Empty run still emits the bias pair
                            state     <= DF_DRAIN;
                            bias_slot <= 1'b1;
                            slot_last <= 1'b1;
`else
                            state <= DF_DONE;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
                DF_FETCH: begin
                    if (k == len_q - ADDR_WIDTH'(1)) begin
                        state <= DF_DRAIN;
                        w_rd  <= 1'b0;
                        i_rd  <= 1'b0;
`ifdef DF_BIAS_EN
                        bias_slot <= 1'b1;
                        slot_last <= 1'b1;
`else
                        slot_last <= 1'b0;
`endif
                    end else begin
                        k      <= k + ADDR_WIDTH'(1);
                        w_addr <= w_addr + ADDR_WIDTH'(1);
                        i_addr <= i_addr + ADDR_WIDTH'(1);
`ifdef DF_BIAS_EN
                        slot_last <= 1'b0;
`else
                        slot_last <= (k + ADDR_WIDTH'(2) == len_q);
`endif
                    end
                end
                DF_DRAIN: begin
                    // Done lines up with the cycle after the final df_rdy
                    if (!pending) begin
                        state <= DF_DONE;
                        done  <= 1'b1;
                    end
                end
                DF_DONE: begin
                    state <= DF_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= DF_IDLE;
            endcase
        end
    end

    assign tag.vld  = w_rd | bias_slot;
    assign tag.last = slot_last;
    assign tag.bsel = bias_slot;

    df_pipe #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag     (tag),
        .w_rdata (w_rdata),
        .i_rdata (i_rdata),
        .bias    (bias_word),
        .pending (pending),
        .df_rdy  (df_rdy),
        .df_last (df_last),
        .data_w  (data_w),
        .data_i  (data_i)
    );

endmodule

// File: tb/tb_df_unit.sv
// Scoreboard bench for df_unit: run-level model queues expected reads, pairs and done pulses.
module tb_df_unit;
    localparam int WW = 16;
    localparam int AW = 8;
`ifdef DF_BIAS_EN
    localparam int BIAS_EN = 1;
`else
    localparam int BIAS_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] len = '0, w_base = '0, i_base = '0;
`ifdef DF_BIAS_EN
    logic [WW-1:0] bias = '0;
`endif
    logic          w_rd, i_rd, df_rdy, df_last, busy, done;
    logic [AW-1:0] w_addr, i_addr;
    logic [WW-1:0] w_rdata, i_rdata, data_w, data_i;

    df_unit dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .w_base(w_base), .i_base(i_base),
`ifdef DF_BIAS_EN
        .bias(bias),
`endif
        .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
        .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata),
        .df_rdy(df_rdy), .data_w(data_w), .data_i(data_i),
        .df_last(df_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WW-1:0] wmem [256];
    logic [WW-1:0] imem [256];
    always @(posedge clk) begin
        if (w_rd) w_rdata <= wmem[w_addr];
        if (i_rd) i_rdata <= imem[i_addr];
    end

    typedef struct { int cyc; logic [AW-1:0] wa; logic [AW-1:0] ia; } rd_t;
    typedef struct { int cyc; logic [WW-1:0] w; logic [WW-1:0] i; logic last; } pr_t;
    rd_t rd_q[$];
    pr_t pr_q[$];
    int  done_q[$];
    int  bs = 1, be = 0, rst_at = -10;
    logic [WW-1:0] hw = '0, hi = '0;
    bit  mon_on = 1'b0;
    int  total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Issue a start request; the model accepts it only when no run is active
    task automatic issue(input int n, input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                         input logic [WW-1:0] b);
        int c0, d;
        logic [AW-1:0] wa, ia;
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b1; len = AW'(n); w_base = wb; i_base = ib;
`ifdef DF_BIAS_EN
        bias = b;
`endif
        if (c0 > be) begin
            for (int j = 0; j < n; j++) begin
                wa = wb + AW'(j);
                ia = ib + AW'(j);
                rd_q.push_back('{c0 + 1 + j, wa, ia});
                pr_q.push_back('{c0 + 3 + j, wmem[wa], imem[ia], (j == n - 1) && (BIAS_EN == 0)});
            end
            if (BIAS_EN != 0) pr_q.push_back('{c0 + 3 + n, b, 16'h1000, 1'b1});
            d = (n == 0 && BIAS_EN == 0) ? c0 + 1 : c0 + 3 + n + BIAS_EN;
            done_q.push_back(d);
            bs = c0 + 1;
            be = d;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cyc < be && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic abort_run();
        int r;
        @(posedge clk); #1;
        r = cyc;
        reset = 1'b1;
        rst_at = r;
        for (int j = rd_q.size() - 1; j >= 0; j--) if (rd_q[j].cyc > r) rd_q.delete(j);
        for (int j = pr_q.size() - 1; j >= 0; j--) if (pr_q[j].cyc > r) pr_q.delete(j);
        for (int j = done_q.size() - 1; j >= 0; j--) if (done_q[j] > r) done_q.delete(j);
        if (be > r) be = r;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: every cycle compare the DUT against the queue heads
    always @(negedge clk) begin
        bit  er, ep, ed;
        rd_t r;
        pr_t p;
        if (mon_on) begin
            if (cyc == rst_at + 1) begin hw = '0; hi = '0; end
            er = rd_q.size() > 0 && rd_q[0].cyc == cyc;
            chk("w_rd", w_rd, er);
            chk("i_rd", i_rd, er);
            if (er) begin
                r = rd_q.pop_front();
                chk("w_addr", w_addr, r.wa);
                chk("i_addr", i_addr, r.ia);
            end
            ep = pr_q.size() > 0 && pr_q[0].cyc == cyc;
            chk("df_rdy", df_rdy, ep);
            if (ep) begin
                p = pr_q.pop_front();
                hw = p.w; hi = p.i;
                chk("df_last", df_last, p.last);
            end else begin
                chk("df_last_idle", df_last, 0);
            end
            chk("data_w", data_w, hw);
            chk("data_i", data_i, hi);
            ed = done_q.size() > 0 && done_q[0] == cyc;
            chk("done", done, ed);
            if (ed) void'(done_q.pop_front());
            chk("busy", busy, (cyc >= bs && cyc <= be));
        end
    end

    initial begin
        int n;
        for (int a = 0; a < 256; a++) begin
            wmem[a] = WW'($urandom);
            imem[a] = WW'($urandom);
        end
        @(posedge clk);
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_w_addr", w_addr, 0);
        chk("rst_i_addr", i_addr, 0);
        repeat (20) @(posedge clk);
        #1;

        issue(3, 8'h10, 8'h20, 16'h0100); wait_idle();
        issue(0, 8'h40, 8'h50, 16'h0200); wait_idle();
        issue(4, 8'hFE, 8'h30, 16'h0300); wait_idle();

        issue(8, 8'h60, 8'h70, 16'h0400);
        repeat (2) @(posedge clk);
        abort_run();
        repeat (3) @(posedge clk);
        issue(2, 8'h80, 8'hF0, 16'h0500);
        issue(7, 8'h11, 8'h22, 16'h0600);
        wait_idle();

        issue(2, 8'h05, 8'h06, 16'h0800); wait_idle();
        issue(1, 8'hFF, 8'hFF, 16'h0900); wait_idle();

        for (int t = 0; t < 16; t++) begin
            n = (t == 7) ? 255 : int'($urandom_range(0, 12));
            issue(n, AW'($urandom), AW'($urandom), WW'($urandom));
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        repeat (6) @(posedge clk);
        chk("queues_empty", rd_q.size() + pr_q.size() + done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
